// File: rtl/instruction_queue_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module : microarch_defs (package)
// Brief  : Shared types, opcode length table and decode helper for the
//          instruction queue assembler.
// Rev    : 1.0 - initial release
// ============================================================================
package microarch_defs;

    typedef enum logic [0:0] {
        EXPECT_OP = 1'b0,
        COLLECT   = 1'b1
    } iq_state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_OPCODE_WIDTH = 4;
    localparam int DEF_MAX_BYTES    = 3;
    localparam int DEF_LEN_W        = $clog2(DEF_MAX_BYTES + 1);

    // Entry layout at the default sizes; the top re-declares it for its own
    // parameter values with the same field order.
    typedef struct packed {
        logic [DEF_LEN_W-1:0]                       length;
        logic [(DEF_MAX_BYTES-1)*DEF_DATA_WIDTH-1:0] imm;
        logic [DEF_OPCODE_WIDTH-1:0]                opcode;
        logic [DEF_DATA_WIDTH-DEF_OPCODE_WIDTH-1:0] operand;
    } instr_entry_t;

    localparam int unsigned INSTR_LEN [16] = '{
        1, 1, 1, 1, 1, 1, 1, 1,
        2, 2, 2, 2,
        3, 3, 3, 3
    };

    function automatic int unsigned instr_length(input logic [3:0] op,
                                                 input int unsigned max_bytes);
        int unsigned len;
        len = INSTR_LEN[op];
        if (len > max_bytes) begin
            len = max_bytes;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_queue_assembler_fifo.sv
`default_nettype none
// ============================================================================
// Module : instr_fifo
// Brief  : Generic DEPTH x WIDTH synchronous FIFO with flush; head is read
//          from registered storage and forced to zero when empty.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_queue_assembler.sv
`default_nettype none
// ============================================================================
// Module : instruction_queue_assembler
// Brief  : Assembles variable-length instructions from a byte stream and
//          queues completed instructions for the controller.
// Rev    : 1.0 - initial release
// ============================================================================
module instruction_queue_assembler
    import microarch_defs::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int MAX_BYTES    = 3,
    parameter int DEPTH        = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OPCODE_WIDTH-1:0]             opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0]  operand,
    output logic [(MAX_BYTES-1)*DATA_WIDTH-1:0] imm,
    output logic [$clog2(MAX_BYTES+1)-1:0]      length,
    output logic                                pending
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam int IMM_W = (MAX_BYTES - 1) * DATA_WIDTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef struct packed {
        logic [LEN_W-1:0]                   length;
        logic [IMM_W-1:0]                   imm;
        logic [OPCODE_WIDTH-1:0]            opcode;
        logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand;
    } entry_t;

    iq_state_t               r_state;
    iq_state_t               w_next_state;
    logic [LEN_W-1:0]        r_idx;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        w_dec_len;
    logic [DATA_WIDTH-1:0]   r_byte0;
    logic [IMM_W-1:0]        r_imm;
    logic [IMM_W-1:0]        w_imm_merged;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [CNT_W-1:0]        w_count;
    entry_t                  w_push_entry;
    entry_t                  w_head;

    assign in_ready  = !flush && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_dec_len = LEN_W'(instr_length(4'(in_data[DATA_WIDTH-1 -: OPCODE_WIDTH]),
                                           MAX_BYTES));
    assign w_last    = (r_idx == (r_len - LEN_ONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EXPECT_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = EXPECT_OP;
        end else if (w_accept) begin
            case (r_state)
                EXPECT_OP: if (w_dec_len != LEN_ONE) w_next_state = COLLECT;
                COLLECT:   if (w_last)               w_next_state = EXPECT_OP;
                default:   w_next_state = EXPECT_OP;
            endcase
        end
    end

    always_comb begin
        pending      = (r_state == COLLECT);
        w_push       = 1'b0;
        w_push_entry = '0;
        w_imm_merged = r_imm;
        for (int b = 0; b < MAX_BYTES - 1; b++) begin
            if (r_idx == LEN_W'(b + 1)) begin
                w_imm_merged[b*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
        case (r_state)
            EXPECT_OP: begin
                if (w_accept && (w_dec_len == LEN_ONE)) begin
                    w_push               = 1'b1;
                    w_push_entry.length  = LEN_ONE;
                    w_push_entry.opcode  = in_data[DATA_WIDTH-1 -: OPCODE_WIDTH];
                    w_push_entry.operand = in_data[DATA_WIDTH-OPCODE_WIDTH-1:0];
                end
            end
            COLLECT: begin
                if (w_accept && w_last) begin
                    w_push               = 1'b1;
                    w_push_entry.length  = r_len;
                    w_push_entry.imm     = w_imm_merged;
                    w_push_entry.opcode  = r_byte0[DATA_WIDTH-1 -: OPCODE_WIDTH];
                    w_push_entry.operand = r_byte0[DATA_WIDTH-OPCODE_WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // Staging is zeroed on every opcode so short instructions carry zero imm bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_byte0 <= '0;
            r_imm   <= '0;
        end else if (flush) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_byte0 <= '0;
            r_imm   <= '0;
        end else if (w_accept) begin
            if (r_state == EXPECT_OP) begin
                r_byte0 <= in_data;
                r_len   <= w_dec_len;
                r_imm   <= '0;
                r_idx   <= LEN_ONE;
            end else begin
                r_imm   <= w_imm_merged;
                r_idx   <= r_idx + LEN_ONE;
            end
        end
    end

    instr_fifo #(
        .WIDTH (LEN_W + IMM_W + DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign opcode  = w_head.opcode;
    assign operand = w_head.operand;
    assign imm     = w_head.imm;
    assign length  = w_head.length;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        (w_count <= CNT_W'(DEPTH)));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full));

endmodule
`default_nettype wire
